// File: rtl/multicycle_datapath_unit.sv
// Multi-cycle datapath for the 16-bit instruction set: PC, 8-entry register file, ALU and
// the IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer talking to handshaked instruction/data memories.
module multicycle_datapath_unit #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic              beq,
  input  logic              bne,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [1:0]        alu_op,
  output logic [3:0]        opcode,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] pc,
  output logic              retire
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(2);

  state_t state, state_next;

  logic [DATA_W-1:0] pc_q, a_q, b_q, alu_out, mdr;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];

  logic c_jump, c_beq, c_bne, c_mem_read, c_mem_write;
  logic c_alu_src, c_reg_dst, c_mem_to_reg, c_reg_write;
  logic [1:0] c_alu_op;

  logic [2:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm, alu_b, alu_y, wb_data;
  logic [3:0]        shamt;
  logic              alu_zero, branch_taken;

  assign opcode = ir[15:12];
  assign rs     = ir[11:9];
  assign rt     = ir[8:6];
  assign rd     = ir[5:3];
  assign imm    = {{(DATA_W-6){ir[5]}}, ir[5:0]};
  assign alu_b  = c_alu_src ? imm : b_q;
  assign shamt  = alu_b[3:0];

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b_q;
  assign wb_data    = c_mem_to_reg ? mdr : alu_out;

  // alu_op 10 defers to the opcode for the R-type function; unknown functions add
  always_comb begin
    alu_y = a_q + alu_b;
    case (c_alu_op)
      2'b01: alu_y = a_q - alu_b;
      2'b10: begin
        case (opcode)
          4'd3:    alu_y = a_q - alu_b;
          4'd4:    alu_y = ~a_q;
          4'd5:    alu_y = a_q << shamt;
          4'd6:    alu_y = a_q >> shamt;
          4'd7:    alu_y = a_q & alu_b;
          4'd8:    alu_y = a_q | alu_b;
          4'd9:    alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
          default: alu_y = a_q + alu_b;
        endcase
      end
      default: alu_y = a_q + alu_b;
    endcase
  end

  assign alu_zero     = (alu_y == '0);
  assign branch_taken = (c_beq & alu_zero) | (c_bne & ~alu_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Requests decode from the registered state only; retire marks the hop back to FETCH
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE:   state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = DECODE;
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        if (c_jump | c_beq | c_bne) begin
          retire     = 1'b1;
          state_next = FETCH;
        end else if (c_mem_read | c_mem_write) begin
          state_next = MEM;
        end else if (c_reg_write) begin
          state_next = WB;
        end else begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = c_mem_write;
        if (dmem_ready) begin
          if (c_mem_write) begin
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // Controls are captured in DECODE so later states are immune to control-unit changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ir           <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      c_jump       <= 1'b0;
      c_beq        <= 1'b0;
      c_bne        <= 1'b0;
      c_mem_read   <= 1'b0;
      c_mem_write  <= 1'b0;
      c_alu_src    <= 1'b0;
      c_reg_dst    <= 1'b0;
      c_mem_to_reg <= 1'b0;
      c_reg_write  <= 1'b0;
      c_alu_op     <= 2'b00;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            ir   <= imem_rdata;
            pc_q <= pc_q + PC_STEP;
          end
        end
        DECODE: begin
          a_q          <= regs[rs];
          b_q          <= regs[rt];
          c_jump       <= jump;
          c_beq        <= beq;
          c_bne        <= bne;
          c_mem_read   <= mem_read;
          c_mem_write  <= mem_write;
          c_alu_src    <= alu_src;
          c_reg_dst    <= reg_dst;
          c_mem_to_reg <= mem_to_reg;
          c_reg_write  <= reg_write;
          c_alu_op     <= alu_op;
        end
        EXEC: begin
          alu_out <= alu_y;
          if (c_jump)            pc_q <= {pc_q[DATA_W-1:13], ir[11:0], 1'b0};
          else if (branch_taken) pc_q <= pc_q + (imm << 1);
        end
        MEM: begin
          if (dmem_ready && !c_mem_write) mdr <= dmem_rdata;
        end
        WB: begin
          if (c_reg_write) regs[c_reg_dst ? rd : rt] <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath_unit.sv
// Bench for multicycle_datapath_unit: plays control unit and both memories, and tracks an
// instruction-level model of PC, registers and data memory to predict every bus transaction.
module tb_multicycle_datapath_unit;

  localparam int            DW     = 16;
  localparam logic [DW-1:0] RST_PC = 16'h0040;

  localparam logic [3:0] OP_LW = 4'd0, OP_SW = 4'd1, OP_SUB = 4'd3, OP_SHL = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd10, OP_BEQ = 4'd11, OP_BNE = 4'd12, OP_NOP = 4'd14;

  logic clk = 1'b0;
  logic rst;
  logic jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
  logic [1:0]    alu_op;
  logic [3:0]    opcode;
  logic          imem_req, imem_ready;
  logic [DW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ready;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [DW-1:0] pc;
  logic          retire;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_r [8];
  logic [DW-1:0] m_mem [logic [DW-1:0]];
  logic [DW-1:0] last_wdata, last_addr, last_pc;

  always #5 clk = ~clk;

  multicycle_datapath_unit #(.DATA_W(DW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_op(alu_op), .opcode(opcode),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire)
  );

  // Control unit: 0 LW, 1 SW, 2-9/15 R-type, 10 ADDI, 11 BEQ, 12 BNE, 13 JMP, 14 NOP
  always_comb begin
    {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write} = '0;
    alu_op = 2'b00;
    case (opcode)
      4'd0: {mem_read, alu_src, mem_to_reg, reg_write} = 4'b1111;
      4'd1: {mem_write, alu_src} = 2'b11;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15: begin
        {reg_dst, reg_write} = 2'b11;
        alu_op = 2'b10;
      end
      4'd10: begin {alu_src, reg_write} = 2'b11; alu_op = 2'b11; end
      4'd11: begin beq = 1'b1; alu_op = 2'b01; end
      4'd12: begin bne = 1'b1; alu_op = 2'b01; end
      4'd13: jump = 1'b1;
      default: ;
    endcase
  end

  task automatic finish_test();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait expired, got no event, want event", tag);
    finish_test();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                        input logic [2:0] rt);
    return {op, rs, rt, rd, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rt, input logic [2:0] rs,
                                        input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] enc_j(input logic [11:0] target);
    return {4'd13, target};
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [DW-1:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'd3:    return a - b;
      4'd4:    return ~a;
      4'd5:    return a << b[3:0];
      4'd6:    return a >> b[3:0];
      4'd7:    return a & b;
      4'd8:    return a | b;
      4'd9:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return a + b;
    endcase
  endfunction

  // Executes one instruction on the model; kind 0 = ends in EXEC, 1 = ALU write, 2 = store, 3 = load
  task automatic model_exec(input logic [15:0] ins, output int kind, output logic [DW-1:0] addr,
                            output logic [DW-1:0] data);
    logic [3:0]    op;
    logic [DW-1:0] imm, a, b, npc;
    op   = ins[15:12];
    imm  = ins[5] ? DW'(ins[5:0]) - DW'(64) : DW'(ins[5:0]);
    a    = m_r[ins[11:9]];
    b    = m_r[ins[8:6]];
    npc  = m_pc + DW'(2);
    kind = 0;
    addr = '0;
    data = '0;
    case (op)
      4'd0:  begin kind = 3; addr = a + imm; data = mem_rd(addr); m_r[ins[8:6]] = data; end
      4'd1:  begin kind = 2; addr = a + imm; data = b; m_mem[addr] = b; end
      4'd10: begin kind = 1; m_r[ins[8:6]] = a + imm; end
      4'd11: if (a == b) npc = npc + imm + imm;
      4'd12: if (a != b) npc = npc + imm + imm;
      4'd13: npc = (npc & 16'hE000) | {3'b000, ins[11:0], 1'b0};
      4'd14: ;
      default: begin kind = 1; m_r[ins[5:3]] = alu_ref(op, a, b); end
    endcase
    m_pc = npc;
  endtask

  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw);
    int kind, n, lat;
    logic [DW-1:0] eaddr, edata;
    n = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    while (!imem_req && n < 8) begin @(posedge clk); #1; n++; end
    if (!imem_req) timeout_fail("fetch_wait");
    checkOutput("fetch_addr", imem_addr, m_pc);
    cyc = 1;
    for (int k = 0; k < iw; k++) begin
      imem_rdata = 16'($urandom);
      step();
      checkOutput("fetch_hold_req", DW'(imem_req), DW'(1));
      checkOutput("fetch_hold_addr", imem_addr, m_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    model_exec(ins, kind, eaddr, edata);
    lat = (kind == 0) ? 3 : (kind == 3) ? 5 : 4;
    step();
    imem_ready = 1'b0;
    imem_rdata = 16'($urandom);
    if (kind >= 2) begin
      n = 0;
      while (!dmem_req && n < 4) begin dmem_ready = 1'($urandom); step(); dmem_ready = 1'b0; n++; end
      if (!dmem_req) timeout_fail("dmem_wait");
      checkOutput("dmem_we", DW'(dmem_we), DW'(kind == 2));
      checkOutput("dmem_addr", dmem_addr, eaddr);
      last_addr = dmem_addr;
      if (kind == 2) begin
        checkOutput("dmem_wdata", dmem_wdata, edata);
        last_wdata = dmem_wdata;
      end
      for (int k = 0; k < dw; k++) begin
        dmem_rdata = DW'($urandom);
        step();
        checkOutput("dmem_hold_req", DW'(dmem_req), DW'(1));
        checkOutput("dmem_hold_addr", dmem_addr, eaddr);
        if (kind == 2) checkOutput("dmem_hold_wdata", dmem_wdata, edata);
      end
      dmem_ready = 1'b1;
      dmem_rdata = edata;
      lat = lat + dw;
      #1;
    end
    n = 0;
    while (!retire && n < 4) begin
      imem_ready = 1'($urandom);
      if (kind < 2) dmem_ready = 1'($urandom);
      step();
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      n++;
    end
    if (!retire) timeout_fail("retire_wait");
    checkOutput("latency", DW'(cyc), DW'(lat + iw));
    step();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    checkOutput("retire_pulse", DW'(retire), DW'(0));
    checkOutput("pc_after", pc, m_pc);
    last_pc = pc;
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    failures++;
    finish_test();
  end

  initial begin
    int n;
    logic [DW-1:0] d;
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    last_wdata = '0;
    last_addr = '0;
    last_pc = '0;
    m_pc = RST_PC;
    for (int i = 0; i < 8; i++) m_r[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_imem_req", DW'(imem_req), DW'(0));
    checkOutput("rst_dmem_req", DW'(dmem_req), DW'(0));
    checkOutput("rst_dmem_we", DW'(dmem_we), DW'(0));
    checkOutput("rst_retire", DW'(retire), DW'(0));
    checkOutput("rst_opcode", DW'(opcode), DW'(0));
    checkOutput("rst_pc", pc, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_no_req", DW'(imem_req), DW'(0));
    @(posedge clk);
    #1;
    checkOutput("first_fetch_req", DW'(imem_req), DW'(1));
    checkOutput("first_fetch_addr", imem_addr, RST_PC);

    // R-type subtract, zero wait states
    run_instr(enc_i(OP_ADDI, 3'd1, 3'd0, 6'd5), 0, 0);
    run_instr(enc_i(OP_ADDI, 3'd2, 3'd0, 6'd3), 0, 0);
    run_instr(enc_r(OP_SUB, 3'd3, 3'd1, 3'd2), 0, 0);
    run_instr(enc_i(OP_SW, 3'd3, 3'd0, 6'd0), 0, 0);
    checkOutput("sub_result", last_wdata, 16'h0002);

    // Build 0xABCD with shifts, store with a slow data memory, reload it
    run_instr(enc_i(OP_ADDI, 3'd5, 3'd0, 6'd4), 0, 0);
    run_instr(enc_i(OP_ADDI, 3'd2, 3'd0, 6'd10), 0, 0);
    run_instr(enc_r(OP_SHL, 3'd2, 3'd2, 3'd5), 0, 0);
    run_instr(enc_i(OP_ADDI, 3'd2, 3'd2, 6'd11), 0, 0);
    run_instr(enc_r(OP_SHL, 3'd2, 3'd2, 3'd5), 1, 0);
    run_instr(enc_i(OP_ADDI, 3'd2, 3'd2, 6'd12), 0, 0);
    run_instr(enc_r(OP_SHL, 3'd2, 3'd2, 3'd5), 0, 0);
    run_instr(enc_i(OP_ADDI, 3'd2, 3'd2, 6'd13), 2, 0);
    run_instr(enc_i(OP_SW, 3'd2, 3'd1, 6'd4), 0, 3);
    checkOutput("store_wdata", last_wdata, 16'hABCD);
    checkOutput("store_addr", last_addr, 16'h0009);
    run_instr(enc_i(OP_LW, 3'd4, 3'd1, 6'd4), 1, 2);
    run_instr(enc_i(OP_SW, 3'd4, 3'd0, 6'd0), 0, 0);
    checkOutput("load_back", last_wdata, 16'hABCD);

    // Branches from 0x0010 with imm = -2
    run_instr(enc_j(12'h008), 0, 0);
    checkOutput("jump_to_0010", last_pc, 16'h0010);
    run_instr(enc_i(OP_BEQ, 3'd0, 3'd0, 6'h3E), 0, 0);
    checkOutput("beq_taken", last_pc, 16'h000E);
    run_instr(enc_j(12'h008), 0, 0);
    run_instr(enc_i(OP_BEQ, 3'd0, 3'd1, 6'h3E), 0, 0);
    checkOutput("beq_not_taken", last_pc, 16'h0012);
    run_instr(enc_j(12'h008), 0, 0);
    run_instr(enc_i(OP_BNE, 3'd0, 3'd0, 6'h3E), 1, 0);
    checkOutput("bne_equal", last_pc, 16'h0012);

    // Hop forward into the top region, then jump inside it
    while (m_pc < 16'hE000) run_instr(enc_i(OP_BEQ, 3'd0, 3'd0, 6'd31), 0, 0);
    run_instr(enc_j(12'h000), 0, 0);
    checkOutput("jump_to_e000", last_pc, 16'hE000);
    run_instr(enc_j(12'h123), 0, 0);
    checkOutput("jump_region", last_pc, 16'hE246);

    // Walk to 0xFFFE and let the fetch wrap the PC; also wrap an add through zero
    while (m_pc < 16'hFFC0) run_instr(enc_i(OP_BEQ, 3'd0, 3'd0, 6'd31), 0, 0);
    d = 16'hFFFE - m_pc;
    if (d != '0) run_instr(enc_i(OP_BEQ, 3'd0, 3'd0, 6'((d - DW'(2)) >> 1)), 0, 0);
    run_instr(enc_i(OP_ADDI, 3'd1, 3'd0, 6'h3F), 0, 0);
    checkOutput("pc_wrap", last_pc, 16'h0000);
    run_instr(enc_i(OP_ADDI, 3'd6, 3'd1, 6'd1), 0, 0);
    run_instr(enc_i(OP_SW, 3'd1, 3'd0, 6'd2), 0, 0);
    checkOutput("all_ones", last_wdata, 16'hFFFF);
    run_instr(enc_i(OP_SW, 3'd6, 3'd0, 6'd2), 0, 0);
    checkOutput("add_wrap_zero", last_wdata, 16'h0000);

    // Random instruction stream with random wait states
    repeat (200) run_instr(16'($urandom), int'($urandom % 3), int'($urandom % 4));
    for (int i = 0; i < 8; i++) run_instr(enc_i(OP_SW, 3'(i), 3'd0, 6'(i)), 0, 1);

    // Reset in the middle of a stalled store
    n = 0;
    while (!imem_req && n < 8) begin @(posedge clk); #1; n++; end
    if (!imem_req) timeout_fail("abort_fetch_wait");
    imem_ready = 1'b1;
    imem_rdata = enc_i(OP_SW, 3'd2, 3'd0, 6'd0);
    step();
    imem_ready = 1'b0;
    n = 0;
    while (!dmem_req && n < 4) begin step(); n++; end
    if (!dmem_req) timeout_fail("abort_dmem_wait");
    checkOutput("abort_store_we", DW'(dmem_we), DW'(1));
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("abort_dmem_req", DW'(dmem_req), DW'(0));
    checkOutput("abort_imem_req", DW'(imem_req), DW'(0));
    checkOutput("abort_retire", DW'(retire), DW'(0));
    checkOutput("abort_pc", pc, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_idle", DW'(imem_req), DW'(0));
    @(posedge clk);
    #1;
    checkOutput("abort_refetch_req", DW'(imem_req), DW'(1));
    m_pc = RST_PC;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    run_instr(enc_i(OP_SW, 3'd4, 3'd0, 6'd0), 0, 0);
    checkOutput("regs_cleared", last_wdata, 16'h0000);
    run_instr(enc_i(OP_LW, 3'd5, 3'd1, 6'd4), 0, 1);
    run_instr(enc_i(OP_SW, 3'd5, 3'd0, 6'd0), 0, 0);

    finish_test();
  end

endmodule
